// File: rtl/ikari_sprite_linebuf.sv
// ikari_sprite_linebuf: double-buffered sprite line buffer feeding the mixer pixel stream (L1D)
//   clk, rst              : clock, synchronous active-high reset
//   line_swap             : HBLANK pulse, swaps draw/display banks
//   wr_valid/wr_ready     : sprite pixel write handshake, target wr_x, value wr_data
//   rd_cen, rd_x          : pixel clock enable and display X; L1D is the displayed pixel
//   draw_bank, init_done  : bank being drawn, both banks cleared after reset
module ikari_sprite_linebuf #(
   parameter int               PIX_W      = 8,
   parameter int               ADDR_W     = 9,
   parameter logic [PIX_W-1:0] CLEAR_VAL  = 8'h7F,
   parameter logic [3:0]       TRANSP_PEN = 4'hF,
   parameter bit               FIRST_WINS = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              line_swap,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_x,
   input  logic [PIX_W-1:0]  wr_data,
   input  logic              rd_cen,
   input  logic [ADDR_W-1:0] rd_x,
   output logic [PIX_W-1:0]  L1D,
   output logic              draw_bank,
   output logic              init_done
);
   typedef enum logic {INIT, RUN} state_t;
   state_t            state, state_nx;
   logic [ADDR_W:0]   cnt;
   logic [PIX_W-1:0]  mem [2**(ADDR_W+1)];
   logic              s1_v, s1_b, s2_v, s2_b, rd_v;
   logic [ADDR_W-1:0] s1_x, s2_x;
   logic [PIX_W-1:0]  s1_d, s2_d, old;
   logic [ADDR_W:0]   rd_a;
   logic              run, accept, commit;
   always_comb begin
      state_nx  = (state == INIT && &cnt) ? RUN : state;
      run       = state == RUN;
      wr_ready  = run && !line_swap;
      init_done = run;
      accept    = wr_valid && wr_ready;
      // S1 sees a pending S2 commit (wins over a clear) or a pending clear before the RAM does
      old       = (s2_v && {s2_b, s2_x} == {s1_b, s1_x}) ? s2_d :
                  (rd_v && rd_a == {s1_b, s1_x})       ? CLEAR_VAL : mem[{s1_b, s1_x}];
      commit    = s1_d[3:0] != TRANSP_PEN && (!FIRST_WINS || old == CLEAR_VAL);
   end
   always_ff @(posedge clk)
      if (rst) state <= INIT;
      else     state <= state_nx;
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         draw_bank <= 1'b0;
         s1_v      <= 1'b0;
         s2_v      <= 1'b0;
         rd_v      <= 1'b0;
         L1D       <= CLEAR_VAL;
      end else begin
         cnt       <= run ? cnt : cnt + 1'b1;
         draw_bank <= draw_bank ^ (run && line_swap);
         s1_v      <= accept;
         s1_x      <= wr_x;
         s1_d      <= wr_data;
         s1_b      <= draw_bank;
         // S2 only carries writes that will actually land
         s2_v      <= s1_v && commit;
         s2_x      <= s1_x;
         s2_d      <= s1_d;
         s2_b      <= s1_b;
         rd_v      <= run && rd_cen;
         rd_a      <= {~draw_bank, rd_x};
         if (rd_v) L1D <= mem[rd_a];
      end
   end
   // Clear-on-read and sprite commit share the RAM; the sprite write is ordered last so it wins
   always_ff @(posedge clk) begin
      if (!run) mem[cnt] <= CLEAR_VAL;
      else begin
         if (rd_v) mem[rd_a] <= CLEAR_VAL;
         if (s2_v) mem[{s2_b, s2_x}] <= s2_d;
      end
   end
endmodule

// File: doc/ikari_sprite_linebuf.md
Name: ikari_sprite_linebuf

Overview:
- Double-buffered sprite line buffer. It is the producer of the 8-bit line-buffer pixel stream (L1D) that the final video mixer consumes.
- The sprite renderer writes pixels for line N+1 into the draw bank while the display bank streams line N out at the pixel clock enable.
- Each display location is cleared to the transparent code as it is read.
- The two banks swap on a line pulse issued during HBLANK.

Parameters:
- PIX_W, 8, pixel width (colour bank plus pen).
- ADDR_W, 9, X address width; each bank holds 2^ADDR_W pixels.
- CLEAR_VAL, 8'h7F, transparent/cleared value, equal to the mixer's "layer off" code.
- TRANSP_PEN, 4'hF, pen value (wr_data[3:0]) that is never written.
- FIRST_WINS, 1, 1 = a write lands only on a location still holding CLEAR_VAL; 0 = last write wins.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active high
- line_swap  in  1  one-cycle pulse at HBLANK start; toggles bank roles
- wr_valid  in  1  sprite pixel write request
- wr_ready  out  1  write accepted when wr_valid and wr_ready are both high
- wr_x  in  ADDR_W  target X
- wr_data  in  PIX_W  pixel value
- rd_cen  in  1  pixel clock enable (CK1 rate)
- rd_x  in  ADDR_W  display X from video timing
- L1D  out  PIX_W  display pixel to the mixer
- draw_bank  out  1  bank currently being written
- init_done  out  1  high once both banks have been cleared

Behaviour:
- Clock and reset: a single clock, clk; reset is synchronous and active-high (rst).
- Reset values: draw_bank=0, L1D=CLEAR_VAL, wr_ready=0, init_done=0, FSM=INIT. Both write pipeline stages are invalidated.
- Reset mid-operation: any in-flight write is dropped and INIT restarts from address 0.
- INIT state:
  - A counter walks all 2*2^ADDR_W locations, one write of CLEAR_VAL per cycle.
  - wr_ready=0 and L1D holds CLEAR_VAL; rd_cen and line_swap are ignored.
  - After the last address, go to RUN and set init_done=1 on the next cycle. The INIT length is exactly 2^(ADDR_W+1) cycles.
- RUN state, write pipeline (draw bank):
  - S1: accept the request, latch x, data and bank = draw_bank; read the current content.
  - S2: commit the write if wr_data[3:0] != TRANSP_PEN and (FIRST_WINS==0 or the old value == CLEAR_VAL).
  - Throughput is 1 pixel/cycle.
  - Back-to-back writes to the same X must forward the S2 committed value into the S1 compare. The second write then sees the first.
  - X arithmetic wraps modulo 2^ADDR_W, with no range error.
  - wr_ready=1 in RUN except in the cycle line_swap is high.
  - A write already in S1/S2 at swap completes into its latched (old draw) bank.
- RUN state, read path (display bank = ~draw_bank):
  - On rd_cen=1 in cycle t, read rd_x; L1D takes that value at the edge ending cycle t+1 (latency 2 edges). L1D holds otherwise.
  - In cycle t+1 the same location is written with CLEAR_VAL. The read must return the pre-clear value.
  - Consecutive rd_cen cycles are legal.
  - rd_cen with no line_swap between two visits to the same X yields CLEAR_VAL on the second visit.
- Swap:
  - On line_swap, draw_bank toggles at the clock edge.
  - A read launched in the swap cycle still uses the old display bank.
  - line_swap coincident with rd_cen and wr_valid: all three complete against pre-swap bank roles; the write is not accepted that cycle (wr_ready=0).
- Port conflicts: the write and clear ports always target different banks in RUN, except during the 1–2 cycle swap overlap. If S2 and the clear ever hit the same bank and address, the sprite write wins.

Test Plan:
- Reset, then wait → init_done rises exactly 1024 cycles after rst drop (ADDR_W=9); wr_ready stays 0 until then; L1D=8'h7F throughout.
- Write x=5 data 8'h23, swap, rd_cen at rd_x=5 → L1D=8'h23 two edges later; re-read x=5 without swap → 8'h7F (cleared).
- FIRST_WINS=1: writes x=10 8'h41 then x=10 8'h52 back-to-back, swap, read → 8'h41. With FIRST_WINS=0 the same stimulus → 8'h52.
- Write x=3 data 8'h1F (pen F), swap, read x=3 → 8'h7F. Write x=511 8'h30 then wr_x=512 wrapped (0) 8'h31 → reads at 511 and 0 give 8'h30 and 8'h31.
- line_swap coincident with wr_valid and rd_cen → wr_ready=0 that cycle; draw_bank toggles; the pending S2 write appears in the new display bank after the swap.
- Assert rst during a write burst mid-line → L1D=8'h7F, init_done=0; after re-INIT, every read in both banks returns 8'h7F.
